// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing the byte-lane data RAM between the core MEM stage (C) and the loader (L).
// Core has fixed priority; a starvation guard and a burst lock protect the loader.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [31:0]       c_addr,
    input  logic [3:0]        c_wstrb,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              l_req,
    input  logic [31:0]       l_addr,
    input  logic [3:0]        l_wstrb,
    input  logic [31:0]       l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {ARB, LOCK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             rd_pend, rd_owner_l, err_pend;
    logic [31:0]      c_rdata_q, l_rdata_q;

    logic        gnt_any, sel_ok, rd_start, wr_err;
    logic [31:0] sel_addr, sel_off, sel_wdata, rsp_data;
    logic [3:0]  sel_wstrb;

    // Grant decision and ownership FSM; no grants while reset is asserted
    always_comb begin
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_nxt  = state;
        starve_nxt = '0;
        if (rst) begin
            if (state == LOCK && l_lock) begin
                l_gnt = l_req;
            end else begin
                l_gnt     = l_req & (~c_req | (starve_cnt == STARVE_LIM));
                c_gnt     = c_req & ~l_gnt;
                state_nxt = (l_gnt & l_lock) ? LOCK : ARB;
            end
            if (l_req & ~l_gnt) begin
                starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Route the granted port to the banks; out-of-range accesses are granted but never reach RAM
    always_comb begin
        gnt_any   = c_gnt | l_gnt;
        sel_addr  = l_gnt ? l_addr  : c_addr;
        sel_wstrb = l_gnt ? l_wstrb : c_wstrb;
        sel_wdata = l_gnt ? l_wdata : c_wdata;
        sel_off   = sel_addr - BASE_ADDR;
        sel_ok    = (sel_addr >= BASE_ADDR) && ((sel_off >> (ADDR_W + 2)) == 32'd0);
        ram_en    = gnt_any & sel_ok;
        ram_we    = ram_en ? sel_wstrb : 4'b0000;
        ram_addr  = sel_off[ADDR_W+1:2];
        ram_wdata = sel_wdata;
        rd_start  = gnt_any & (sel_wstrb == 4'b0000);
        wr_err    = gnt_any & ~sel_ok & (sel_wstrb != 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend    <= 1'b0;
            rd_owner_l <= 1'b0;
            err_pend   <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            rd_pend    <= rd_start;
            rd_owner_l <= l_gnt;
            err_pend   <= rd_start & ~sel_ok;
            if (c_rvalid) c_rdata_q <= c_rdata;
            if (l_rvalid) l_rdata_q <= l_rdata;
        end
    end

    // Responses: data valid one cycle after grant, last value held for waveform debug
    always_comb begin
        rsp_data = err_pend ? 32'h0 : ram_rdata;
        c_rvalid = rst & rd_pend & ~rd_owner_l;
        l_rvalid = rst & rd_pend & rd_owner_l;
        c_rdata  = !rst ? 32'h0 : (c_rvalid ? rsp_data : c_rdata_q);
        l_rdata  = !rst ? 32'h0 : (l_rvalid ? rsp_data : l_rdata_q);
        c_err    = (c_rvalid & err_pend) | (wr_err & c_gnt);
        l_err    = (l_rvalid & err_pend) | (wr_err & l_gnt);
    end
endmodule
